truth_table_sweep: RTL and testbench

Synchronous stimulus-and-capture stage for 4-input combinational lab circuits.
- On `start`, drives `{a,b,c,d}` through all 16 input codes in ascending order, holding each for a programmable dwell.
- Samples the circuit's single output `f` at the end of each dwell and assembles the result into a 16-bit truth-table word.
- Sits directly upstream of the circuit under test (drives its `a..d`) and consumes its `f`. Replaces hand-written delay sequences with a reusable hardware sweeper.

---
 rtl/truth_table_pkg.sv | 14 +
 rtl/sweep_dwell_timer.sv | 27 ++
 rtl/truth_table_sweep.sv | 134 +++++++++++++
 tb/tb_truth_table_sweep.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and constants for the 4-input truth-table sweeper.
package truth_table_pkg;

  localparam int N_IN    = 4;
  localparam int N_CODES = 16;

  typedef logic [N_CODES-1:0] tt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell timer: 8-bit counter that flags the last cycle of each DWELL-cycle window.
module sweep_dwell_timer #(
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

  logic [7:0] cnt;

  assign last = (cnt == LAST_CNT);

  // Count while enabled, restarting after the last cycle of the window.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/truth_table_sweep.sv
// Truth-table sweeper: drives {a,b,c,d} through codes 0..15, holding each for
// DWELL cycles, and captures f at the end of each dwell into tt.
// Optional feature macro: TT_EXPECT_CHECK_EN adds expected/mismatch/pass.
//
// state | meaning
// IDLE  | stimulus parked at 0, waiting for start
// DRIVE | stimulus = idx, capturing f on the last cycle of each dwell
module truth_table_sweep
  import truth_table_pkg::*;
#(
  parameter int DWELL = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            f,
`ifdef TT_EXPECT_CHECK_EN
  input  logic [15:0]     expected,
  output logic [15:0]     mismatch,
  output logic            pass,
`endif
  output logic            a,
  output logic            b,
  output logic            c,
  output logic            d,
  output logic [N_IN-1:0] idx,
  output logic            busy,
  output logic            done,
  output logic [15:0]     tt
);

  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_CODES - 1);

  state_t          state, state_n;
  logic [N_IN-1:0] idx_n;
  tt_t             tt_n;
  logic            done_n;
  logic            clr, en, last, capture;

  sweep_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .last (last)
  );

  // idx returns to 0 on completion, so the stimulus can simply mirror idx.
  assign {a, b, c, d} = idx;
  assign busy         = (state == DRIVE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    tt_n    = tt;
    done_n  = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        clr = 1'b1;
        if (start) begin
          tt_n    = '0;
          idx_n   = '0;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        en = 1'b1;
        if (last) begin
          capture   = 1'b1;
          tt_n[idx] = f;
          if (idx == LAST_IDX) begin
            idx_n   = '0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath registers: code index, captured table and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      tt   <= '0;
      done <= 1'b0;
    end else begin
      idx  <= idx_n;
      tt   <= tt_n;
      done <= done_n;
    end
  end

`ifdef TT_EXPECT_CHECK_EN
  tt_t  exp_q;
  tt_t  mismatch_n;

  // Fold the current capture into the mismatch vector.
  always_comb begin
    mismatch_n      = mismatch;
    mismatch_n[idx] = f ^ exp_q[idx];
  end

  // Latch the reference at start; track mismatches and settle pass at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q    <= '0;
      mismatch <= '0;
      pass     <= 1'b0;
    end else if (state == IDLE && start) begin
      exp_q    <= expected;
      mismatch <= '0;
      pass     <= 1'b0;
    end else if (capture) begin
      mismatch <= mismatch_n;
      if (idx == LAST_IDX) pass <= (mismatch_n == '0);
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sweep.sv
module tb_truth_table_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sel;
  logic [15:0] fn10, fn1, exp10, exp1;
  int          checks = 0;
  int          passes = 0;

  logic        a10, b10, c10, d10, busy10, done10;
  logic [3:0]  idx10;
  logic [15:0] tt10;
  logic        a1, b1, c1, d1, busy1, done1;
  logic [3:0]  idx1;
  logic [15:0] tt1;
  logic [15:0] mis10, mis1;
  logic        pass10, pass1;

  wire [3:0] code10 = {a10, b10, c10, d10};
  wire [3:0] code1  = {a1, b1, c1, d1};
  wire       f10    = fn10[code10];
  wire       f1     = fn1[code1];
  wire       start10 = start & ~sel;
  wire       start1  = start & sel;

  wire [3:0]  code_s = sel ? code1 : code10;
  wire [3:0]  idx_s  = sel ? idx1  : idx10;
  wire        busy_s = sel ? busy1 : busy10;
  wire        done_s = sel ? done1 : done10;
  wire [15:0] tt_s   = sel ? tt1   : tt10;
  wire [15:0] mis_s  = sel ? mis1  : mis10;
  wire        pass_s = sel ? pass1 : pass10;

  always #5 clk = ~clk;

  truth_table_sweep #(.DWELL(10)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .f(f10),
`ifdef TT_EXPECT_CHECK_EN
    .expected(exp10), .mismatch(mis10), .pass(pass10),
`endif
    .a(a10), .b(b10), .c(c10), .d(d10),
    .idx(idx10), .busy(busy10), .done(done10), .tt(tt10)
  );

  truth_table_sweep #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f(f1),
`ifdef TT_EXPECT_CHECK_EN
    .expected(exp1), .mismatch(mis1), .pass(pass1),
`endif
    .a(a1), .b(b1), .c(c1), .d(d1),
    .idx(idx1), .busy(busy1), .done(done1), .tt(tt1)
  );

`ifndef TT_EXPECT_CHECK_EN
  assign mis10  = '0;
  assign mis1   = '0;
  assign pass10 = 1'b0;
  assign pass1  = 1'b0;
`endif

  task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One sweep on the selected DUT; expectations come from the arithmetic timing
  // rules: after edge E0+m the code is m/dwell and the first m/dwell bits of tt
  // are captured.
  task automatic sweep(input logic s, input int dwell, input logic [15:0] fn,
                       input logic [15:0] expv, input int restart_at,
                       input int rst_at, input logic chain);
    int          ncap;
    logic [16:0] mask;
    sel = s;
    if (s) begin fn1 = fn; exp1 = expv; end
    else   begin fn10 = fn; exp10 = expv; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("e0_busy", 16'(busy_s), 16'd1);
    chk("e0_code", 16'(code_s), 16'd0);
    chk("e0_done", 16'(done_s), 16'd0);
    chk("e0_tt",   tt_s,        16'h0000);
    for (int m = 1; m <= 16 * dwell; m++) begin
      if (m == restart_at) start = 1'b1;
      if (m == rst_at)     rst   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (m == rst_at) begin
        rst = 1'b0;
        chk("rst_tt",   tt_s,        16'h0000);
        chk("rst_idx",  16'(idx_s),  16'd0);
        chk("rst_busy", 16'(busy_s), 16'd0);
        chk("rst_done", 16'(done_s), 16'd0);
        chk("rst_code", 16'(code_s), 16'd0);
        return;
      end
      ncap = m / dwell;
      mask = (17'd1 << ncap) - 17'd1;
      chk("tt_progress", tt_s, fn & mask[15:0]);
      if (m < 16 * dwell) begin
        chk("code", 16'(code_s), 16'(m / dwell));
        chk("idx",  16'(idx_s),  16'(m / dwell));
        chk("busy", 16'(busy_s), 16'd1);
        chk("done_early", 16'(done_s), 16'd0);
      end else begin
        chk("done_pulse", 16'(done_s), 16'd1);
        chk("busy_end",   16'(busy_s), 16'd0);
        chk("code_end",   16'(code_s), 16'd0);
`ifdef TT_EXPECT_CHECK_EN
        chk("mismatch", mis_s, fn ^ expv);
        chk("pass", 16'(pass_s), 16'(fn == expv));
`endif
      end
    end
    if (!chain) begin
      @(posedge clk); #1;
      chk("done_single", 16'(done_s), 16'd0);
      chk("tt_hold",     tt_s,        fn);
      chk("busy_idle",   16'(busy_s), 16'd0);
    end
  endtask

  logic [15:0] r;

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0;
    fn10 = '0; fn1 = '0; exp10 = '0; exp1 = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk("idle10", {busy10, done10, code10, idx10, 6'd0}, 16'h0000);
      chk("idle10_tt", tt10, 16'h0000);
      chk("idle1", {busy1, done1, code1, idx1, 6'd0}, 16'h0000);
      chk("idle1_tt", tt1, 16'h0000);
    end

    sweep(1'b0, 10, 16'hF888, 16'hF888, 0, 0, 1'b0);
    sweep(1'b1, 1,  16'h6996, 16'h6996, 0, 0, 1'b0);

    r = 16'($urandom); sweep(1'b1, 1, r, r, 0, 0, 1'b1);
    r = 16'($urandom); sweep(1'b1, 1, r, r, 0, 0, 1'b1);
    r = 16'($urandom); sweep(1'b1, 1, r, r, 0, 0, 1'b0);

    r = 16'($urandom); sweep(1'b0, 10, r, r, 40, 0, 1'b0);
    r = 16'($urandom); sweep(1'b0, 10, r, r, 0, 75, 1'b0);
    r = 16'($urandom); sweep(1'b0, 10, r, r, 0, 0, 1'b0);

    sweep(1'b0, 10, 16'hF888 ^ 16'h0020, 16'hF888, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
